// File: rtl/axis_pkg.sv
// Shared AXI-stream width-conversion helpers used by the packing and unpacking blocks.
package axis_pkg;

  // Lane 0 sits at the LSB end of a wide word.
  localparam int unsigned AXIS_FIRST_LANE = 0;

  // Effective lane count: 0 or anything above the ratio means a full word.
  function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned ratio);
    return ((cnt == 0) || (cnt > ratio)) ? ratio : cnt;
  endfunction

  // Bit offset of a lane inside a wide word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/axis_unpacker.sv
// AXI-stream down-converter: one wide word of RATIO lanes in, lanes out LSB-first as narrow beats.
module axis_unpacker
  import axis_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned RATIO  = 4,
  localparam int unsigned CNT_W  = $clog2(RATIO + 1)
) (
  input  logic                    s_aclk,
  input  logic                    s_areset,
  input  logic                    s_tvalid,
  input  logic [DATA_W*RATIO-1:0] s_tdata,
  input  logic [CNT_W-1:0]        s_tcnt,
  input  logic                    s_tlast,
  output logic                    s_tready,
  input  logic                    m_tready,
  output logic                    m_tvalid,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tlast
);

  localparam int unsigned WIDE_W = DATA_W * RATIO;

  logic              r_full;
  logic [WIDE_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;

  logic              w_last_lane;
  logic              w_s_hs;
  logic              w_m_hs;
  logic [CNT_W-1:0]  w_eff_cnt;

  assign w_last_lane = (r_cnt == CNT_W'(1));
  assign w_eff_cnt   = CNT_W'(clamp_cnt(32'(s_tcnt), RATIO));

  // Ready when empty, or when the final lane leaves this cycle so the next word loads seamlessly.
  assign s_tready = !s_areset && (!r_full || (m_tready && w_last_lane));
  assign w_s_hs   = s_tvalid && s_tready;
  assign w_m_hs   = r_full && m_tready;

  assign m_tvalid = r_full;
  assign m_tdata  = r_data[lane_lsb(AXIS_FIRST_LANE, DATA_W) +: DATA_W];
  assign m_tlast  = r_full && r_last && w_last_lane;

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (w_s_hs) begin
      r_full <= 1'b1;
      r_data <= s_tdata;
      r_cnt  <= w_eff_cnt;
      r_last <= s_tlast;
    end else if (w_m_hs) begin
      if (w_last_lane) begin
        r_full <= 1'b0;
        r_data <= '0;
        r_cnt  <= '0;
      end else begin
        r_data <= r_data >> DATA_W;
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_unpacker.sv
// Directed bench for axis_unpacker at DATA_W=8, RATIO=4.
module tb_axis_unpacker;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RATIO  = 4;
  localparam int unsigned CNT_W  = 3;

  logic                    clk;
  logic                    rst;
  logic                    s_tvalid;
  logic [DATA_W*RATIO-1:0] s_tdata;
  logic [CNT_W-1:0]        s_tcnt;
  logic                    s_tlast;
  logic                    s_tready;
  logic                    m_tready;
  logic                    m_tvalid;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tlast;

  int n_tests = 0;
  int n_fail  = 0;

  axis_unpacker #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
    .s_aclk   (clk),
    .s_areset (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tcnt   (s_tcnt),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tready (m_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, ".tvalid"}, 32'(m_tvalid), 32'(v));
    chk({tag, ".tdata"},  32'(m_tdata),  32'(d));
    chk({tag, ".tlast"},  32'(m_tlast),  32'(l));
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] c, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tcnt   = c;
    s_tlast  = l;
  endtask

  initial begin
    logic [31:0] w;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tcnt   = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    rst      = 1'b0;
    #1;
    rst = 1'b1;
    send_word(32'h11223344, 3'd0, 1'b1);

    // Reset held 3 cycles with a word offered
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rst.s_tready", 32'(s_tready), 32'd0);
      chk_beat("rst", 1'b0, 8'h00, 1'b0);
      adv();
    end
    rst      = 1'b0;
    s_tvalid = 1'b0;
    mid();
    chk("rel.s_tready", 32'(s_tready), 32'd1);
    chk("rel.m_tvalid", 32'(m_tvalid), 32'd0);
    adv();

    // Full word, count 0 means all four lanes
    w = 32'hDDCCBBAA;
    send_word(w, 3'd0, 1'b1);
    mid();
    chk("full.accept", 32'(s_tready), 32'd1);
    adv();
    s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk_beat($sformatf("full.b%0d", i), 1'b1, w[i*8 +: 8], i == 3);
      adv();
    end
    mid();
    chk("full.idle", 32'(m_tvalid), 32'd0);
    adv();

    // Partial word of two lanes
    send_word(32'h44332211, 3'd2, 1'b1);
    mid();
    chk("part.accept", 32'(s_tready), 32'd1);
    adv();
    s_tvalid = 1'b0;
    mid();
    chk_beat("part.b0", 1'b1, 8'h11, 1'b0);
    chk("part.b0.s_tready", 32'(s_tready), 32'd0);
    adv();
    mid();
    chk_beat("part.b1", 1'b1, 8'h22, 1'b1);
    chk("part.b1.s_tready", 32'(s_tready), 32'd1);
    adv();
    mid();
    chk("part.idle", 32'(m_tvalid), 32'd0);
    adv();

    // Back-to-back full words, no bubble between them
    send_word(32'h04030201, 3'd0, 1'b0);
    mid();
    chk("b2b.acceptA", 32'(s_tready), 32'd1);
    adv();
    send_word(32'h08070605, 3'd4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      mid();
      chk_beat($sformatf("b2b.b%0d", i), 1'b1, 8'(i + 1), i == 7);
      chk($sformatf("b2b.s_tready%0d", i), 32'(s_tready), 32'((i == 3) || (i == 7)));
      adv();
      if (i == 3) s_tvalid = 1'b0;
    end
    mid();
    chk("b2b.idle", 32'(m_tvalid), 32'd0);
    adv();

    // Backpressure mid-word while another word is offered
    send_word(32'hA4A3A2A1, 3'd0, 1'b1);
    adv();
    s_tvalid = 1'b0;
    mid();
    chk_beat("bp.b0", 1'b1, 8'hA1, 1'b0);
    adv();
    m_tready = 1'b0;
    send_word(32'hFFFFFFFF, 3'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      mid();
      chk_beat($sformatf("bp.stall%0d", i), 1'b1, 8'hA2, 1'b0);
      chk($sformatf("bp.s_tready%0d", i), 32'(s_tready), 32'd0);
      adv();
    end
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    mid();
    chk_beat("bp.b1", 1'b1, 8'hA2, 1'b0);
    adv();
    mid();
    chk_beat("bp.b2", 1'b1, 8'hA3, 1'b0);
    adv();
    mid();
    chk_beat("bp.b3", 1'b1, 8'hA4, 1'b1);
    adv();
    mid();
    chk("bp.idle", 32'(m_tvalid), 32'd0);
    adv();

    // Count 7 clamps to four lanes
    w = 32'h34333231;
    send_word(w, 3'd7, 1'b1);
    adv();
    s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk_beat($sformatf("clamp.b%0d", i), 1'b1, w[i*8 +: 8], i == 3);
      adv();
    end
    mid();
    chk("clamp.idle", 32'(m_tvalid), 32'd0);
    adv();

    // Reset after two beats discards the rest of the word
    send_word(32'h54535251, 3'd0, 1'b1);
    adv();
    s_tvalid = 1'b0;
    mid();
    chk_beat("mrst.b0", 1'b1, 8'h51, 1'b0);
    adv();
    mid();
    chk_beat("mrst.b1", 1'b1, 8'h52, 1'b0);
    adv();
    rst = 1'b1;
    #1;
    chk_beat("mrst.async", 1'b0, 8'h00, 1'b0);
    chk("mrst.s_tready", 32'(s_tready), 32'd0);
    adv();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk_beat($sformatf("mrst.after%0d", i), 1'b0, 8'h00, 1'b0);
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
